led_flash_ctrl: RTL and testbench

//   Sequences the board LED bank through timed flash patterns.
//   A host (button/FSM logic) selects a pattern, a repeat count and start/pause/stop.

---
 rtl/led_flash_ctrl_pkg.sv | 35 +++
 rtl/led_flash_ctrl_tick_gen.sv | 41 ++++
 rtl/led_flash_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_led_flash_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_flash_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_flash_ctrl_pkg
//   Shared encodings for the LED flash controller: FSM state encoding, pattern
//   mode encoding and a helper that returns the pass length of each pattern.
// -----------------------------------------------------------------------------
package led_flash_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_BLINK     = 2'd0,
        MODE_CHASE_L   = 2'd1,
        MODE_CHASE_R   = 2'd2,
        MODE_PING_PONG = 2'd3
    } mode_t;

    localparam int PASS_W = 4;

    // Number of pattern ticks that make up one pass of the given mode.
    // Ping-pong visits every bit once in each direction without repeating
    // the end bits, hence 2*(led_w-1).
    function automatic int pass_len(mode_t m, int led_w);
        case (m)
            MODE_BLINK:     return 2;
            MODE_PING_PONG: return 2 * (led_w - 1);
            default:        return led_w;
        endcase
    endfunction

endpackage

// File: rtl/led_flash_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Prescaler producing a one-cycle step tick every TICK_DIV enabled cycles.
//   The counter runs 0..TICK_DIV-1 while en is high and wraps; tick is high
//   during the enabled cycle in which the counter sits at TICK_DIV-1.
// Ports
//   clk   in   system clock
//   rst   in   asynchronous reset, active-low
//   clr   in   synchronous clear of the counter (wins over en)
//   en    in   count enable
//   tick  out  step strobe
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_ONE;
        end
    end

    assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/led_flash_ctrl.sv
// -----------------------------------------------------------------------------
// led_flash_ctrl
//   Sequences the LED bank through timed flash patterns. A host selects a
//   pattern mode and repeat count, then starts, pauses or stops the run.
//   Pattern steps are paced by tick_gen.
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-low
//   start       in   1-cycle pulse, begins a run when idle
//   stop        in   1-cycle pulse, aborts a run
//   pause       in   level, freezes the run while high
//   mode        in   0=blink all, 1=chase left, 2=chase right, 3=ping-pong
//   repeat_cnt  in   passes to run, 0 = run forever
//   led         out  LED drive, registered
//   busy        out  high in RUN/HOLD
//   done        out  1-cycle pulse at normal completion
//
// FSM states
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | LEDs off, waiting for start
//   RUN     | prescaler running, pattern advances on each tick
//   HOLD    | paused: prescaler, step and pattern frozen
//   DONE    | one-cycle completion pulse, LEDs off, then IDLE
// -----------------------------------------------------------------------------
module led_flash_ctrl
    import led_flash_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int LED_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [3:0]         repeat_cnt,
    output logic [LED_W-1:0]   led,
    output logic               busy,
    output logic               done
);

    localparam int STEP_W = $clog2(2 * LED_W);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [PASS_W-1:0] PASS_MAX = '1;
    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [3:0]          rep_q, rep_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                dir_q, dir_d;      // 1 = moving towards the MSB
    logic [LED_W-1:0]    led_q, led_d;

    logic                tick;
    logic                last_step;
    logic [PASS_W-1:0]   pass_next;
    logic [LED_W-1:0]    led_step;
    logic                dir_step;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_IDLE),
        .en   (state_q == ST_RUN),
        .tick (tick)
    );

    function automatic logic [LED_W-1:0] init_pattern(mode_t m);
        case (m)
            MODE_BLINK:   return '1;
            MODE_CHASE_R: return {1'b1, {(LED_W-1){1'b0}}};
            default:      return LED_W'(1);
        endcase
    endfunction

    assign last_step = (step_q == STEP_W'(pass_len(mode_q, LED_W) - 1));
    // Saturates so that a free-running (repeat_cnt=0) run never wraps.
    assign pass_next = (pass_q == PASS_MAX) ? pass_q : pass_q + PASS_ONE;

    // Next pattern value and direction for a step in the latched mode.
    always_comb begin
        led_step = led_q;
        dir_step = dir_q;
        case (mode_q)
            MODE_BLINK:   led_step = ~led_q;
            MODE_CHASE_L: led_step = {led_q[LED_W-2:0], led_q[LED_W-1]};
            MODE_CHASE_R: led_step = {led_q[0], led_q[LED_W-1:1]};
            MODE_PING_PONG: begin
                led_step = dir_q ? (led_q << 1) : (led_q >> 1);
                if (led_step[LED_W-1]) begin
                    dir_step = 1'b0;
                end else if (led_step[0]) begin
                    dir_step = 1'b1;
                end
            end
            default: led_step = led_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rep_d   = rep_q;
        step_d  = step_q;
        pass_d  = pass_q;
        dir_d   = dir_q;
        led_d   = led_q;

        case (state_q)
            ST_IDLE: begin
                led_d = '0;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    mode_d  = mode_t'(mode);
                    rep_d   = repeat_cnt;
                    step_d  = '0;
                    pass_d  = '0;
                    dir_d   = 1'b1;
                    led_d   = init_pattern(mode_t'(mode));
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end else begin
                    if (tick) begin
                        led_d = led_step;
                        dir_d = dir_step;
                        if (last_step) begin
                            step_d = '0;
                            pass_d = pass_next;
                        end else begin
                            step_d = step_q + STEP_ONE;
                        end
                    end
                    if (tick && last_step && (rep_q != 4'd0) && (pass_next == rep_q)) begin
                        state_d = ST_DONE;
                        led_d   = '0;
                    end else if (pause) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                led_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_BLINK;
            rep_q  <= '0;
            step_q <= '0;
            pass_q <= '0;
            dir_q  <= 1'b1;
            led_q  <= '0;
        end else begin
            mode_q <= mode_d;
            rep_q  <= rep_d;
            step_q <= step_d;
            pass_q <= pass_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
        end
    end

    assign led  = led_q;
    assign busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_led_flash_ctrl.sv
module tb_led_flash_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic [1:0]  mode;
    logic [3:0]  repeat_cnt;
    logic [15:0] led;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    led_flash_ctrl #(
        .TICK_DIV (4),
        .LED_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .repeat_cnt (repeat_cnt),
        .led        (led),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  rep;
        int          n;       // clock edges after the start edge
        logic [15:0] led;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] m, input logic [3:0] r, input int n,
                       input logic [15:0] l, input logic b, input logic d);
        vec_t v;
        v.mode = m; v.rep = r; v.n = n; v.led = l; v.busy = b; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] el,
                         input logic eb, input logic ed);
        n_checks++;
        if (led === el && busy === eb && done === ed) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got led=%h busy=%b done=%b, expected led=%h busy=%b done=%b",
                     name, led, busy, done, el, eb, ed);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
    endtask

    // Pulses start; returns 1ns after the edge that samples it. The mode and
    // repeat inputs are scrambled afterwards so latching is exercised.
    task automatic start_run(input logic [1:0] m, input logic [3:0] r);
        step(1);
        mode       = m;
        repeat_cnt = r;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
        mode       = ~m;
        repeat_cnt = ~r;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 2'd0; repeat_cnt = 4'd0;
        #1;
        check("reset", 16'h0000, 1'b0, 1'b0);
        step(2);
        rst = 1'b1;
        step(1);
        check("after_reset", 16'h0000, 1'b0, 1'b0);

        // chase left, one pass
        add(2'd1, 4'd1, 0,   16'h0001, 1, 0);
        add(2'd1, 4'd1, 3,   16'h0001, 1, 0);
        add(2'd1, 4'd1, 4,   16'h0002, 1, 0);
        add(2'd1, 4'd1, 60,  16'h8000, 1, 0);
        add(2'd1, 4'd1, 63,  16'h8000, 1, 0);
        add(2'd1, 4'd1, 64,  16'h0000, 0, 1);
        add(2'd1, 4'd1, 65,  16'h0000, 0, 0);
        // blink, two passes
        add(2'd0, 4'd2, 0,   16'hFFFF, 1, 0);
        add(2'd0, 4'd2, 4,   16'h0000, 1, 0);
        add(2'd0, 4'd2, 8,   16'hFFFF, 1, 0);
        add(2'd0, 4'd2, 12,  16'h0000, 1, 0);
        add(2'd0, 4'd2, 15,  16'h0000, 1, 0);
        add(2'd0, 4'd2, 16,  16'h0000, 0, 1);
        add(2'd0, 4'd2, 17,  16'h0000, 0, 0);
        // ping-pong, one pass
        add(2'd3, 4'd1, 4,   16'h0002, 1, 0);
        add(2'd3, 4'd1, 56,  16'h4000, 1, 0);
        add(2'd3, 4'd1, 60,  16'h8000, 1, 0);
        add(2'd3, 4'd1, 64,  16'h4000, 1, 0);
        add(2'd3, 4'd1, 116, 16'h0002, 1, 0);
        add(2'd3, 4'd1, 120, 16'h0000, 0, 1);
        add(2'd3, 4'd1, 121, 16'h0000, 0, 0);
        // chase right, one pass
        add(2'd2, 4'd1, 0,   16'h8000, 1, 0);
        add(2'd2, 4'd1, 4,   16'h4000, 1, 0);
        add(2'd2, 4'd1, 60,  16'h0001, 1, 0);
        add(2'd2, 4'd1, 64,  16'h0000, 0, 1);
        // free-running past 16 passes
        add(2'd1, 4'd0, 64,  16'h0001, 1, 0);
        add(2'd1, 4'd0, 1028, 16'h0002, 1, 0);
        // maximum repeat count
        add(2'd0, 4'd15, 119, 16'h0000, 1, 0);
        add(2'd0, 4'd15, 120, 16'h0000, 0, 1);

        foreach (vecs[i]) begin
            go_idle();
            start_run(vecs[i].mode, vecs[i].rep);
            if (vecs[i].n > 0) step(vecs[i].n);
            check($sformatf("vec%0d_m%0d_r%0d_n%0d", i, vecs[i].mode, vecs[i].rep, vecs[i].n),
                  vecs[i].led, vecs[i].busy, vecs[i].done);
        end

        // async reset mid-run
        go_idle();
        start_run(2'd0, 4'd3);
        step(6);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_mid_run", 16'h0000, 1'b0, 1'b0);
        step(1);
        rst = 1'b1;
        step(2);
        check("idle_after_async_reset", 16'h0000, 1'b0, 1'b0);
        start_run(2'd1, 4'd1);
        step(4);
        check("prescaler_cleared_by_reset", 16'h0002, 1'b1, 1'b0);

        // pause for 10 cycles starting at cycle 9
        go_idle();
        start_run(2'd2, 4'd1);
        step(8);
        check("pause_pre", 16'h2000, 1'b1, 1'b0);
        pause = 1'b1;
        step(7);
        check("pause_frozen", 16'h2000, 1'b1, 1'b0);
        step(3);
        pause = 1'b0;
        step(3);
        check("pause_resume_wait", 16'h2000, 1'b1, 1'b0);
        step(1);
        check("pause_resume_tick", 16'h1000, 1'b1, 1'b0);
        step(51);
        check("pause_before_done", 16'h0001, 1'b1, 1'b0);
        step(1);
        check("pause_done_delayed", 16'h0000, 1'b0, 1'b1);

        // start while busy ignored, stop aborts, start&stop in idle
        go_idle();
        start_run(2'd1, 4'd0);
        step(7);
        mode  = 2'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_ignored", 16'h0004, 1'b1, 1'b0);
        step(4);
        check("restart_ignored_later", 16'h0008, 1'b1, 1'b0);
        step(7);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_abort", 16'h0000, 1'b0, 1'b0);
        step(1);
        check("stop_no_done", 16'h0000, 1'b0, 1'b0);
        mode  = 2'd0;
        repeat_cnt = 4'd1;
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", 16'h0000, 1'b0, 1'b0);
        step(4);
        check("start_stop_idle_later", 16'h0000, 1'b0, 1'b0);

        // stop beats a tick
        go_idle();
        start_run(2'd1, 4'd1);
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_beats_tick", 16'h0000, 1'b0, 1'b0);

        // stop beats completion
        go_idle();
        start_run(2'd0, 4'd1);
        step(7);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_beats_done", 16'h0000, 1'b0, 1'b0);
        step(1);
        check("stop_beats_done_after", 16'h0000, 1'b0, 1'b0);

        // stop while held
        go_idle();
        start_run(2'd1, 4'd0);
        step(2);
        pause = 1'b1;
        step(2);
        check("hold_busy", 16'h0001, 1'b1, 1'b0);
        stop = 1'b1;
        step(1);
        stop  = 1'b0;
        pause = 1'b0;
        check("stop_in_hold", 16'h0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
